// File: rtl/pause_pkg.sv
// Shared types and helpers for the pause / screen-dim controller.
package pause_pkg;

    // Controller state, also visible on the top-level debug output.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        FADE   = 2'd2,
        DIMMED = 2'd3
    } pause_state_t;

    // Width of the fade_level port: enough bits to hold 0..fade_max.
    function automatic int flw(input int fade_max);
        return (fade_max < 1) ? 1 : $clog2(fade_max + 1);
    endfunction

endpackage

// File: rtl/pause_src_latch.sv
// One pause request source: rising-edge toggle latch or plain level pass-through.
module pause_src_latch #(
    parameter bit IS_TOGGLE = 1'b0
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic pause_req,
    input  logic clear_toggle,
    output logic active
);

    logic req_d;
    logic primed;
    logic latch_q;

    // Edge detect and toggle latch. primed masks the first edge after reset so a
    // button still held through reset is treated as already seen.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            req_d   <= 1'b0;
            primed  <= 1'b0;
            latch_q <= 1'b0;
        end else begin
            req_d  <= pause_req;
            primed <= 1'b1;
            if (clear_toggle) begin
                latch_q <= 1'b0;
            end else if (IS_TOGGLE && primed && pause_req && !req_d) begin
                latch_q <= ~latch_q;
            end
        end
    end

    assign active = IS_TOGGLE ? latch_q : pause_req;

endmodule

// File: rtl/pause_dim_ctl.sv
// Merges pause sources into one registered pause and fades the video after a long armed pause.
module pause_dim_ctl
    import pause_pkg::*;
#(
    parameter int unsigned           NSRC        = 4,
    parameter logic [NSRC-1:0]       TOGGLE_MASK = 4'b0001,
    parameter logic [NSRC-1:0]       DIM_MASK    = 4'b0001,
    parameter int unsigned           CW          = 8,
    parameter int unsigned           CTLW        = 4,
    parameter int unsigned           TW          = 32,
    parameter logic [TW-1:0]         DIM_TICKS   = 32'h7270E00,
    parameter logic [TW-1:0]         STEP_TICKS  = 32'h0B71B00,
    parameter int unsigned           FADE_MAX    = 2
) (
    input  logic                        clk_sys,
    input  logic                        reset_n,
    input  logic [NSRC-1:0]             pause_req,
    input  logic                        clear_toggle,
    input  logic [3*CW-1:0]             rgb_in,
    input  logic [CTLW-1:0]             ctl_in,
    output logic [3*CW-1:0]             rgb_out,
    output logic [CTLW-1:0]             ctl_out,
    output logic                        pause,
    output logic                        dimmed,
    output logic [flw(FADE_MAX)-1:0]    fade_level,
    output logic [1:0]                  state_dbg
);

    localparam int FLW = flw(FADE_MAX);

    if (DIM_TICKS == '0 || STEP_TICKS == '0) begin : g_bad_ticks
        $error("pause_dim_ctl: DIM_TICKS and STEP_TICKS must be non-zero");
    end
    if (FADE_MAX < 1 || FADE_MAX > CW - 1) begin : g_bad_fade
        $error("pause_dim_ctl: FADE_MAX must be in 1..CW-1");
    end

    logic [NSRC-1:0] active;
    logic            armed;
    pause_state_t    state;
    logic [TW-1:0]   timer;
    logic [FLW-1:0]  fade_next;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        pause_src_latch #(
            .IS_TOGGLE (TOGGLE_MASK[i])
        ) u_src (
            .clk_sys      (clk_sys),
            .reset_n      (reset_n),
            .pause_req    (pause_req[i]),
            .clear_toggle (clear_toggle),
            .active       (active[i])
        );
    end

    assign armed     = |(active & DIM_MASK);
    assign fade_next = fade_level + FLW'(1);
    assign state_dbg = state;

    // Merged pause to the core, one register after the per-source select.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pause <= 1'b0;
        end else begin
            pause <= |active;
        end
    end

    // Dim FSM with its timer; losing armed drops straight back to RUN undimmed.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= RUN;
            timer      <= '0;
            fade_level <= '0;
            dimmed     <= 1'b0;
        end else if (!armed) begin
            state      <= RUN;
            timer      <= '0;
            fade_level <= '0;
            dimmed     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    timer      <= '0;
                    fade_level <= '0;
                    dimmed     <= 1'b0;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (timer == DIM_TICKS - TW'(1)) begin
                        timer      <= '0;
                        fade_level <= FLW'(1);
                        if (FADE_MAX == 1) begin
                            state  <= DIMMED;
                            dimmed <= 1'b1;
                        end else begin
                            state  <= FADE;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                FADE: begin
                    if (timer == STEP_TICKS - TW'(1)) begin
                        timer      <= '0;
                        fade_level <= fade_next;
                        if (fade_next == FLW'(FADE_MAX)) begin
                            state  <= DIMMED;
                            dimmed <= 1'b1;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DIMMED: begin
                    dimmed <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Video pipe: one register stage, each channel shifted right by the current fade level.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rgb_out <= '0;
            ctl_out <= '0;
        end else begin
            rgb_out <= {rgb_in[3*CW-1:2*CW] >> fade_level,
                        rgb_in[2*CW-1:CW]   >> fade_level,
                        rgb_in[CW-1:0]      >> fade_level};
            ctl_out <= ctl_in;
        end
    end

endmodule
